// File: rtl/mem_access_if.sv
// Byte-wide memory bus between the mem_access stage and the data memory.
// The stage drives the request side (master); the memory answers (slave).
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage of the bf8b core. Moves load/store data one byte per
// handshake over a byte-wide bus, assembles loads little-endian and
// zero-extended, and hands writeback op/funct3/reg_addr/val with a one-cycle
// ready pulse. Optional feature macro: MEM_ALIGN_CHECK_EN (adds misaligned_o
// and turns misaligned 16/32-bit accesses into an immediate zero result).
module mem_access #(
    parameter int         XLEN           = 32,
    parameter int         ADDR_WIDTH     = 32,
    parameter int         REG_ADDR_WIDTH = 4,
    parameter logic [6:0] OP_LOAD        = 7'b0000011,
    parameter logic [6:0] OP_STORE       = 7'b0100011,
    parameter logic [1:0] MEM_ACC_8      = 2'b00,
    parameter logic [1:0] MEM_ACC_16     = 2'b01,
    parameter logic [1:0] MEM_ACC_32     = 2'b10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic [6:0]                op_i,
    input  logic [2:0]                funct3_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_i,
    input  logic [XLEN-1:0]           alu_result_i,
    input  logic [XLEN-1:0]           store_data_i,
    mem_access_if.master              mem_bus,
    output logic [6:0]                op_out_o,
    output logic [2:0]                funct3_out_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_out_o,
    output logic [XLEN-1:0]           val_o,
    output logic                      ready_o,
    output logic                      busy_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                      misaligned_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the last byte of an access; size code 11 is treated as a word.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        case (size)
            MEM_ACC_8:  last_byte_idx = 2'd0;
            MEM_ACC_16: last_byte_idx = 2'd1;
            MEM_ACC_32: last_byte_idx = 2'd3;
            default:    last_byte_idx = 2'd3;
        endcase
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    // Halfwords need an even address, words (and code 11) need a word address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            MEM_ACC_8:  is_misaligned = 1'b0;
            MEM_ACC_16: is_misaligned = a[0];
            MEM_ACC_32: is_misaligned = (a != 2'b00);
            default:    is_misaligned = (a != 2'b00);
        endcase
    endfunction

    logic misaligned_q, misaligned_d;
`endif

    state_t                    state_q, state_d;
    logic [6:0]                op_q, op_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]           sdata_q, sdata_d;
    logic [1:0]                byte_idx_q, byte_idx_d;
    logic [1:0]                last_idx_q, last_idx_d;
    logic [XLEN-1:0]           val_q, val_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]                mem_wdata_q, mem_wdata_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      is_mem_s;

    assign is_mem_s = (op_i == OP_LOAD) || (op_i == OP_STORE);

    // Next-state and next-output logic; all bus and writeback outputs are registered.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        funct3_d    = funct3_q;
        reg_addr_d  = reg_addr_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        byte_idx_d  = byte_idx_q;
        last_idx_d  = last_idx_q;
        val_d       = val_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ready_d     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    op_d       = op_i;
                    funct3_d   = funct3_i;
                    reg_addr_d = reg_addr_i;
                    addr_d     = alu_result_i[ADDR_WIDTH-1:0];
                    sdata_d    = store_data_i;
                    byte_idx_d = 2'd0;
                    last_idx_d = last_byte_idx(funct3_i[1:0]);
`ifdef MEM_ALIGN_CHECK_EN
                    misaligned_d = 1'b0;
`endif
                    if (is_mem_s) begin
                        // Loads assemble into a cleared value; stores report zero.
                        val_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
                        if (is_misaligned(funct3_i[1:0], alu_result_i[1:0])) begin
                            misaligned_d = 1'b1;
                            state_d      = ST_DONE;
                            ready_d      = 1'b1;
                        end else begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = (op_i == OP_STORE);
                            mem_addr_d  = alu_result_i[ADDR_WIDTH-1:0];
                            mem_wdata_d = store_data_i[7:0];
                            state_d     = ST_XFER;
                        end
`else
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op_i == OP_STORE);
                        mem_addr_d  = alu_result_i[ADDR_WIDTH-1:0];
                        mem_wdata_d = store_data_i[7:0];
                        state_d     = ST_XFER;
`endif
                    end else begin
                        val_d   = alu_result_i;
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (mem_bus.mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        val_d[{byte_idx_q, 3'b000} +: 8] = mem_bus.mem_rdata;
                    end else begin
                        val_d = val_q;
                    end
                    if (byte_idx_q == last_idx_q) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = ST_DONE;
                        ready_d   = 1'b1;
                    end else begin
                        byte_idx_d  = byte_idx_q + 2'd1;
                        mem_addr_d  = addr_q + ADDR_WIDTH'(byte_idx_d);
                        mem_wdata_d = sdata_q[{byte_idx_d, 3'b000} +: 8];
                    end
                end else begin
                    // Waiting for the memory: every bus output holds.
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 7'd0;
            funct3_q    <= 3'd0;
            reg_addr_q  <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            byte_idx_q  <= 2'd0;
            last_idx_q  <= 2'd0;
            val_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            funct3_q    <= funct3_d;
            reg_addr_q  <= reg_addr_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            byte_idx_q  <= byte_idx_d;
            last_idx_q  <= last_idx_d;
            val_q       <= val_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign mem_bus.mem_req   = mem_req_q;
    assign mem_bus.mem_we    = mem_we_q;
    assign mem_bus.mem_addr  = mem_addr_q;
    assign mem_bus.mem_wdata = mem_wdata_q;
    assign op_out_o          = op_q;
    assign funct3_out_o      = funct3_q;
    assign reg_addr_out_o    = reg_addr_q;
    assign val_o             = val_q;
    assign ready_o           = ready_q;
    assign busy_o            = busy_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned_o      = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table-driven operations plus hand-written
// sequences (en held while busy, reset mid-transfer). Expected bus transfers
// and writeback records are queued at stimulus time and popped on handshakes.
module tb_mem_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  ra;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [6:0]  op_o;
    logic [2:0]  f3_o;
    logic [3:0]  ra_o;
    logic [31:0] val_o;
    logic        ready_o;
    logic        busy_o;
    logic        mis_o;

    mem_access_if #(.ADDR_WIDTH(32)) bus ();

    mem_access dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .op_i           (op),
        .funct3_i       (f3),
        .reg_addr_i     (ra),
        .alu_result_i   (alu),
        .store_data_i   (sd),
        .mem_bus        (bus),
        .op_out_o       (op_o),
        .funct3_out_o   (f3_o),
        .reg_addr_out_o (ra_o),
        .val_o          (val_o),
        .ready_o        (ready_o),
        .busy_o         (busy_o)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misaligned_o   (mis_o)
`endif
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign mis_o = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [7:0] wdata; } xfer_t;
    typedef struct { logic [6:0] op; logic [2:0] f3; logic [3:0] ra; logic [31:0] val; logic mis; int lat; } wb_t;
    typedef struct { logic [6:0] op; logic [2:0] f3; logic [3:0] ra; logic [31:0] alu; logic [31:0] sd; int wt; logic [31:0] exp; } vec_t;

    xfer_t       xq[$];
    wb_t         wq[$];
    logic [7:0]  mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          drive_cyc = 0;
    logic [31:0] hold_addr = 32'd0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory responder and writeback monitor; runs mid-cycle, away from the active edge.
    task automatic respond();
        xfer_t e;
        wb_t   w;
        if (bus.mem_req && !rst) begin
            if (wcnt > 0) chk("addr_hold", bus.mem_addr, hold_addr);
            else hold_addr = bus.mem_addr;
            if (wcnt == wait_cfg) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
                if (bus.mem_we) mem[bus.mem_addr[9:0]] = bus.mem_wdata;
                else bus.mem_rdata = mem[bus.mem_addr[9:0]];
                if (xq.size() == 0) begin
                    chk("unexpected_xfer_addr", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = xq.pop_front();
                    chk("xfer_we", {31'd0, bus.mem_we}, {31'd0, e.we});
                    chk("xfer_addr", bus.mem_addr, e.addr);
                    if (e.we) chk("xfer_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.wdata});
                end
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = 8'h00;
                wcnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
        if (ready_o) begin
            if (wq.size() == 0) begin
                chk("unexpected_ready", {31'd0, ready_o}, 32'd0);
            end else begin
                w = wq.pop_front();
                chk("wb_op", {25'd0, op_o}, {25'd0, w.op});
                chk("wb_funct3", {29'd0, f3_o}, {29'd0, w.f3});
                chk("wb_reg_addr", {28'd0, ra_o}, {28'd0, w.ra});
                chk("wb_val", val_o, w.val);
                chk("wb_latency", 32'(cyc - drive_cyc), 32'(w.lat));
`ifdef MEM_ALIGN_CHECK_EN
                chk("wb_misaligned", {31'd0, mis_o}, {31'd0, w.mis});
`endif
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) respond();

    // Queue expected transfers/writeback for one operation and issue a one-cycle en.
    task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic [3:0] r,
                         input logic [31:0] a, input logic [31:0] s, input int wt,
                         input logic [31:0] ev);
        int    n;
        logic  is_mem;
        logic  mis;
        xfer_t e;
        wb_t   w;
        is_mem = (o == OP_LOAD) || (o == OP_STORE);
        n = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = is_mem && (((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00)));
`endif
        if (is_mem && !mis) begin
            for (int i = 0; i < n; i++) begin
                e.we    = (o == OP_STORE);
                e.addr  = a + 32'(i);
                e.wdata = s[8*i +: 8];
                xq.push_back(e);
            end
        end
        w.op  = o;
        w.f3  = f;
        w.ra  = r;
        w.val = ev;
        w.mis = mis;
        w.lat = (is_mem && !mis) ? (n + 1 + n * wt) : 1;
        wq.push_back(w);
        wait_cfg  = wt;
        op        = o;
        f3        = f;
        ra        = r;
        alu       = a;
        sd        = s;
        en        = 1'b1;
        drive_cyc = cyc;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Wait (bounded) until every queued writeback has been seen and the stage is idle.
    task automatic drain(input string name);
        for (int k = 0; k < 80 && (wq.size() != 0 || busy_o); k++) begin
            @(posedge clk);
            #1;
        end
        if (wq.size() != 0) begin
            chk({name, "_ready_timeout"}, 32'(wq.size()), 32'd0);
            wq.delete();
        end
        chk({name, "_xfers_left"}, 32'(xq.size()), 32'd0);
        xq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; op = 7'd0; f3 = 3'd0; ra = 4'd0; alu = 32'd0; sd = 32'd0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'h00;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
        mem[10'h104] = 8'h9A; mem[10'h105] = 8'hBC; mem[10'h007] = 8'hF0;

        vecs[0] = '{OP_ALU,   3'b000, 4'd5,  32'h1234_5678, 32'h0,         0, 32'h1234_5678};
        vecs[1] = '{OP_LOAD,  3'b010, 4'd1,  32'h0000_0100, 32'h0,         0, 32'h1234_5678};
        vecs[2] = '{OP_LOAD,  3'b000, 4'd2,  32'h0000_0007, 32'h0,         3, 32'h0000_00F0};
        vecs[3] = '{OP_STORE, 3'b001, 4'd3,  32'h0000_0020, 32'hAABB_CCDD, 0, 32'h0};
        vecs[4] = '{OP_LOAD,  3'b101, 4'd4,  32'h0000_0100, 32'h0,         1, 32'h0000_5678};
        vecs[5] = '{OP_STORE, 3'b010, 4'd6,  32'h0000_0040, 32'hCAFE_BABE, 2, 32'h0};
        vecs[6] = '{OP_LOAD,  3'b010, 4'd7,  32'h0000_0040, 32'h0,         0, 32'hCAFE_BABE};
        vecs[7] = '{OP_LOAD,  3'b111, 4'd8,  32'h0000_0100, 32'h0,         0, 32'h1234_5678};
        vecs[8] = '{OP_ALUI,  3'b111, 4'd15, 32'hFFFF_FFFF, 32'h1111_1111, 0, 32'hFFFF_FFFF};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[9] = '{OP_LOAD,  3'b010, 4'd9,  32'h0000_0102, 32'h0,         0, 32'h0};
`else
        vecs[9] = '{OP_LOAD,  3'b010, 4'd9,  32'h0000_0102, 32'h0,         0, 32'hBC9A_1234};
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk("rst_val", val_o, 32'd0);
        chk("rst_op_out", {25'd0, op_o}, 32'd0);
        chk("rst_ready_busy", {30'd0, ready_o, busy_o}, 32'd0);
        chk("rst_misaligned", {31'd0, mis_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            issue(vecs[v].op, vecs[v].f3, vecs[v].ra, vecs[v].alu, vecs[v].sd, vecs[v].wt, vecs[v].exp);
            drain($sformatf("vec%0d", v));
        end
        chk("store_mem_0x21", {24'd0, mem[10'h021]}, 32'h0000_00CC);

        // en held high (with changing fields) while busy must be ignored.
        issue(OP_LOAD, 3'b010, 4'd3, 32'h0000_0100, 32'h0, 0, 32'h1234_5678);
        en = 1'b1; op = OP_ALU; alu = 32'hDEAD_BEEF; ra = 4'd12;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        en = 1'b0;
        drain("en_while_busy");
        chk("hold_after_ready_val", val_o, 32'h1234_5678);

        // Reset in the middle of a word load: only bytes 0 and 1 complete.
        issue(OP_LOAD, 3'b010, 4'd4, 32'h0000_0100, 32'h0, 0, 32'h0);
        void'(wq.pop_back());
        void'(xq.pop_back());
        void'(xq.pop_back());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_mid_byte2_addr", bus.mem_addr, 32'h0000_0102);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_val", val_o, 32'd0);
        chk("rst_mid_ready", {31'd0, ready_o}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_xfers_left", 32'(xq.size()), 32'd0);
        issue(OP_LOAD, 3'b000, 4'd2, 32'h0000_0007, 32'h0, 3, 32'h0000_00F0);
        drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
